regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//  Shares the single register-file write port (writeReg/writeData/control_RegWrite)
//  between NUM_REQ writeback sources (e.g. 0=ALU, 1=load, 2=link/jal).
//  Round-robin (or fixed-priority) grant, valid/ready handshake per requester,
//  and a registered write stage driving the register file one cycle after acceptance.
//  Also keeps a saturating contention counter for performance debug.
// PARAMETERS
//  NUM_REQ  3   number of requesters, legal range 2..8
//  AW       5   register address width
//  DW       32  write data width
//  RR_EN    1   1 = round-robin grant; 0 = fixed priority, lowest index wins
//  CW       16  contention counter width
// PORTS
//  clk           in   1            system clock, all state on rising edge
//  rst           in   1            asynchronous, active-low reset (0 = reset)
//  wb_hold       in   1            1 = accept nothing this cycle (all req_ready=0)
//  req_valid     in   NUM_REQ      requester i has a write pending
//  req_addr      in   NUM_REQ*AW   requester i dest reg at [i*AW +: AW]
//  req_data      in   NUM_REQ*DW   requester i data at [i*DW +: DW]
//  req_ready     out  NUM_REQ      one-hot or zero; transfer i = valid[i]&ready[i]
//  wr_en         out  1            to control_RegWrite
//  wr_addr       out  AW           to writeReg
//  wr_data       out  DW           to writeData
//  last_grant    out  clog2(NUM_REQ)  index of most recently accepted requester
//  conflict_cnt  out  CW           cycles with >=2 valid requests (saturating)
// BEHAVIOUR
//  Reset (rst=0, async): wr_en=0, wr_addr=0, wr_data=0, last_grant=0, rr_ptr=0,
//   conflict_cnt=0, req_ready=0 while rst=0. A write accepted in the cycle reset asserts
//   is dropped; wr_en clears immediately, not at the next edge.
//  Grant (combinational): if wb_hold=1 or no valid -> no grant, req_ready=0.
//   RR_EN=1: grant the first valid index at or after rr_ptr, searching cyclically.
//   RR_EN=0: grant the lowest valid index; rr_ptr is unused and stays 0.
//   req_ready[g]=1 only for granted g. Ready depends on valid and hold only;
//   requesters must not gate valid on ready.
//  Requester rules: once valid[i]=1, addr/data are held stable until the transfer.
//   Dropping valid before the transfer is illegal (bench asserts it).
//  Write stage (rising edge, rst=1):
//   on transfer: wr_en<=1, wr_addr<=req_addr[g], wr_data<=req_data[g], last_grant<=g,
//     rr_ptr<=(g==NUM_REQ-1)?0:g+1.
//   with no transfer: wr_en<=0; wr_addr, wr_data, last_grant and rr_ptr hold.
//   Latency: acceptance in cycle N -> wr_en high in cycle N+1, so the write lands at
//   the edge ending cycle N+1. Throughput is one write per cycle with no bubbles.
//  Fairness: with RR_EN=1 and k requesters continuously valid, each is granted once
//   every k accepted cycles. No requester waits more than NUM_REQ-1 accepted grants.
//  Same-address contention: no merging. Each request is a separate write in grant
//   order; the later grant wins in the register file.
//  Address 0 is not special: passed through unchanged.
//  conflict_cnt: +1 on every edge where popcount(req_valid)>=2, including when
//   wb_hold=1. Holds at 2^CW-1. Cleared only by reset.
//  wb_hold=1: no transfers, rr_ptr frozen, wr_en<=0 next edge. A write already in the
//   output stage still completes.
// TESTING
//  1 reset: drive rst=0 mid-stream while wr_en=1 -> wr_en, wr_addr, wr_data and
//    conflict_cnt read 0 before the next edge; no write after rst rises until a new transfer.
//  2 single req: valid[1]=1, addr=5, data=32'hDEADBEEF in cycle N -> ready[1]=1 in N;
//    wr_en=1, wr_addr=5, wr_data=DEADBEEF in N+1 only.
//  3 round robin: NUM_REQ=3, all valid for 6 cycles from reset -> grant order
//    0,1,2,0,1,2; conflict_cnt=6.
//  4 fixed priority: RR_EN=0, valid=3'b110 for 3 cycles, then 3'b100 ->
//    grants 1,1,1,2; last_grant=2.
//  5 hold: all valid, wb_hold=1 for 2 cycles mid-sequence -> req_ready=0, wr_en=0 after
//    one cycle, rr_ptr unchanged; order resumes exactly where it stopped.
//  6 saturation: CW=4, valid=3'b011 for 20 cycles -> conflict_cnt stops at 15.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares one registered register-file write port among NUM_REQ writeback sources
module regfile_wb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int AW = 5,
  parameter int DW = 32,
  parameter bit RR_EN = 1'b1,
  parameter int CW = 16,
  localparam int GW = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_hold,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*AW-1:0] req_addr,
  input  logic [NUM_REQ*DW-1:0] req_data,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic                  wr_en,
  output logic [AW-1:0]         wr_addr,
  output logic [DW-1:0]         wr_data,
  output logic [GW-1:0]         last_grant,
  output logic [CW-1:0]         conflict_cnt
);
  logic [GW-1:0] rr_ptr, gnt;
  logic gnt_v;
  // descending scan so the first valid index at or after rr_ptr wins
  always_comb begin
    int i;
    i = 0;
    gnt = '0;
    gnt_v = 1'b0;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      i = (int'(rr_ptr) + k) % NUM_REQ;
      if (req_valid[i]) begin
        gnt = GW'(i);
        gnt_v = 1'b1;
      end
    end
    gnt_v = gnt_v & rst & ~wb_hold;
  end
  assign req_ready = gnt_v ? NUM_REQ'(1) << gnt : '0;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_en <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      last_grant <= '0;
      rr_ptr <= '0;
      conflict_cnt <= '0;
    end else begin
      wr_en <= gnt_v;
      if (gnt_v) begin
        wr_addr <= req_addr[gnt*AW +: AW];
        wr_data <= req_data[gnt*DW +: DW];
        last_grant <= gnt;
        if (RR_EN) rr_ptr <= (gnt == GW'(NUM_REQ-1)) ? '0 : gnt + 1'b1;
      end
      if ($countones(req_valid) >= 2 && conflict_cnt != '1) conflict_cnt <= conflict_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: round-robin, fixed-priority and 4-bit-counter instances checked against a queue-free behavioural model
module tb_regfile_wb_arbiter;
  logic clk = 1'b0;
  logic rst, hold;
  logic [2:0] valid;
  logic [14:0] addr_v;
  logic [95:0] data_v;
  logic [2:0] rdy [3];
  logic en [3];
  logic [4:0] wa [3];
  logic [31:0] wd [3];
  logic [1:0] lg [3];
  logic [15:0] cc [3];
  logic [3:0] cc_sat;
  int checks = 0, errors = 0;
  // per-instance configuration: 0 = round robin, 1 = fixed priority, 2 = round robin with CW=4
  int rr_cfg [3] = '{1, 0, 1};
  int cap [3] = '{65535, 65535, 15};
  int m_ptr [3], m_last [3], m_cnt [3];
  logic m_en [3];
  logic [4:0] m_addr [3];
  logic [31:0] m_data [3];
  always #5 clk = ~clk;
  regfile_wb_arbiter u_rr (.clk(clk), .rst(rst), .wb_hold(hold), .req_valid(valid), .req_addr(addr_v),
    .req_data(data_v), .req_ready(rdy[0]), .wr_en(en[0]), .wr_addr(wa[0]), .wr_data(wd[0]),
    .last_grant(lg[0]), .conflict_cnt(cc[0]));
  regfile_wb_arbiter #(.RR_EN(1'b0)) u_fp (.clk(clk), .rst(rst), .wb_hold(hold), .req_valid(valid),
    .req_addr(addr_v), .req_data(data_v), .req_ready(rdy[1]), .wr_en(en[1]), .wr_addr(wa[1]),
    .wr_data(wd[1]), .last_grant(lg[1]), .conflict_cnt(cc[1]));
  regfile_wb_arbiter #(.CW(4)) u_sat (.clk(clk), .rst(rst), .wb_hold(hold), .req_valid(valid),
    .req_addr(addr_v), .req_data(data_v), .req_ready(rdy[2]), .wr_en(en[2]), .wr_addr(wa[2]),
    .wr_data(wd[2]), .last_grant(lg[2]), .conflict_cnt(cc_sat));
  assign cc[2] = {12'b0, cc_sat};
  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  // index the model grants this cycle, or -1
  function automatic int pick(int c);
    int s;
    if (!rst || hold || valid == 3'b000) return -1;
    s = rr_cfg[c] ? m_ptr[c] : 0;
    for (int k = 0; k < 3; k++) if (valid[(s + k) % 3]) return (s + k) % 3;
    return -1;
  endfunction
  always @(posedge clk or negedge rst) begin
    for (int c = 0; c < 3; c++) begin
      if (!rst) begin
        m_ptr[c] <= 0;
        m_last[c] <= 0;
        m_cnt[c] <= 0;
        m_en[c] <= 1'b0;
        m_addr[c] <= '0;
        m_data[c] <= '0;
      end else begin
        m_en[c] <= pick(c) >= 0;
        if (pick(c) >= 0) begin
          m_addr[c] <= addr_v[pick(c)*5 +: 5];
          m_data[c] <= data_v[pick(c)*32 +: 32];
          m_last[c] <= pick(c);
          m_ptr[c] <= (pick(c) + 1) % 3;
        end
        if ($countones(valid) >= 2) m_cnt[c] <= (m_cnt[c] + 1 > cap[c]) ? cap[c] : m_cnt[c] + 1;
      end
    end
  end
  always @(negedge clk) begin
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("dut%0d ready", c), 64'(rdy[c]), pick(c) < 0 ? 64'd0 : 64'd1 << pick(c));
      chk($sformatf("dut%0d wr_en", c), 64'(en[c]), 64'(m_en[c]));
      chk($sformatf("dut%0d wr_addr", c), 64'(wa[c]), 64'(m_addr[c]));
      chk($sformatf("dut%0d wr_data", c), 64'(wd[c]), 64'(m_data[c]));
      chk($sformatf("dut%0d last_grant", c), 64'(lg[c]), 64'(m_last[c]));
      chk($sformatf("dut%0d conflict_cnt", c), 64'(cc[c]), 64'(m_cnt[c]));
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic set_defaults();
    for (int i = 0; i < 3; i++) begin
      addr_v[i*5 +: 5] = 5'(i + 1);
      data_v[i*32 +: 32] = 32'hA000_0000 + 32'(i);
    end
  endtask
  initial begin
    logic [2:0] hold_rdy [6] = '{3'b100, 3'b001, 3'b000, 3'b000, 3'b010, 3'b100};
    logic hold_en [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    rst = 1'b0;
    hold = 1'b0;
    valid = 3'b111;
    set_defaults();
    step();
    chk("reset ready", 64'(rdy[0]), 64'd0);
    chk("reset wr_en", 64'(en[0]), 64'd0);
    chk("reset conflict_cnt", 64'(cc[0]), 64'd0);
    rst = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("rr order %0d", k), 64'(rdy[0]), 64'd1 << (k % 3));
      step();
    end
    valid = 3'b000;
    @(negedge clk);
    chk("rr conflict_cnt", 64'(cc[0]), 64'd6);
    chk("rr last_grant", 64'(lg[0]), 64'd2);
    chk("rr last wr_addr", 64'(wa[0]), 64'd3);
    step();
    addr_v[5 +: 5] = 5'd5;
    data_v[32 +: 32] = 32'hDEADBEEF;
    valid = 3'b010;
    @(negedge clk);
    chk("single ready", 64'(rdy[0]), 64'b010);
    chk("single wr_en before", 64'(en[0]), 64'd0);
    step();
    valid = 3'b000;
    @(negedge clk);
    chk("single wr_en", 64'(en[0]), 64'd1);
    chk("single wr_addr", 64'(wa[0]), 64'd5);
    chk("single wr_data", 64'(wd[0]), 64'hDEADBEEF);
    step();
    @(negedge clk);
    chk("single wr_en after", 64'(en[0]), 64'd0);
    chk("single wr_addr held", 64'(wa[0]), 64'd5);
    set_defaults();
    step();
    valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      hold = (k == 2 || k == 3);
      @(negedge clk);
      chk($sformatf("hold ready %0d", k), 64'(rdy[0]), 64'(hold_rdy[k]));
      chk($sformatf("hold wr_en %0d", k), 64'(en[0]), 64'(hold_en[k]));
      step();
    end
    hold = 1'b0;
    for (int k = 0; k < 4; k++) begin
      valid = k < 3 ? 3'b110 : 3'b100;
      @(negedge clk);
      chk($sformatf("fixed ready %0d", k), 64'(rdy[1]), k < 3 ? 64'b010 : 64'b100);
      step();
    end
    valid = 3'b000;
    @(negedge clk);
    chk("fixed last_grant", 64'(lg[1]), 64'd2);
    chk("fixed wr_addr", 64'(wa[1]), 64'd3);
    step();
    rst = 1'b0;
    #2;
    rst = 1'b1;
    valid = 3'b011;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk($sformatf("sat cnt %0d", k), 64'(cc_sat), k < 15 ? 64'(k) : 64'd15);
      step();
    end
    @(negedge clk);
    chk("sat final", 64'(cc_sat), 64'd15);
    chk("wide cnt", 64'(cc[0]), 64'd20);
    chk("pre-reset wr_en", 64'(en[0]), 64'd1);
    #1;
    rst = 1'b0;
    #1;
    chk("async wr_en", 64'(en[0]), 64'd0);
    chk("async wr_addr", 64'(wa[0]), 64'd0);
    chk("async wr_data", 64'(wd[0]), 64'd0);
    chk("async conflict_cnt", 64'(cc[0]), 64'd0);
    chk("async ready", 64'(rdy[0]), 64'd0);
    chk("async sat cnt", 64'(cc_sat), 64'd0);
    valid = 3'b000;
    step();
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk($sformatf("post-reset wr_en %0d", k), 64'(en[0]), 64'd0);
      step();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
